// File: rtl/ws281x_bit_serializer.sv
// Pixel-word to bit-strobe serializer feeding the WS281x waveform stage.
// Shifts each accepted word out MSB first and appends a latch low-time after the last pixel.
module ws281x_bit_serializer #(
  parameter int unsigned PIX_WIDTH     = 24,
  parameter int unsigned RST_CNT_WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     pix_valid_in,
  input  logic [PIX_WIDTH-1:0]     pix_data_in,
  input  logic                     pix_last_in,
  output logic                     pix_ready_out,
  output logic                     bit_rdy_out,
  output logic                     bit_data_out,
  input  logic                     bit_done_in,
  input  logic [RST_CNT_WIDTH-1:0] rst_cnt_in,
  output logic                     busy_out,
  output logic                     frame_done_out
);

  localparam int unsigned BitCntW = $clog2(PIX_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StLatch} state_e;

  state_e                   state_q;
  logic [PIX_WIDTH-1:0]     shift_q;
  logic [BitCntW-1:0]       bits_left_q;
  logic                     last_q;
  logic [RST_CNT_WIDTH-1:0] latch_cnt_q;
  logic                     pix_ready_q;
  logic                     bit_rdy_q;
  logic                     bit_data_q;
  logic                     busy_q;
  logic                     frame_done_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bits_left_q  <= '0;
      last_q       <= 1'b0;
      latch_cnt_q  <= '0;
      pix_ready_q  <= 1'b0;
      bit_rdy_q    <= 1'b0;
      bit_data_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bit_rdy_q    <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pix_valid_in && pix_ready_q) begin
            shift_q     <= pix_data_in;
            last_q      <= pix_last_in;
            bits_left_q <= BitCntW'(PIX_WIDTH);
            // Outputs are registered, so the first strobe is launched on the accept edge.
            bit_rdy_q   <= 1'b1;
            bit_data_q  <= pix_data_in[PIX_WIDTH-1];
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StSend;
          end else begin
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        StSend: begin
          shift_q     <= shift_q << 1;
          bits_left_q <= bits_left_q - 1'b1;
          state_q     <= StWait;
        end
        StWait: begin
          if (bit_done_in) begin
            if (bits_left_q != '0) begin
              bit_rdy_q  <= 1'b1;
              bit_data_q <= shift_q[PIX_WIDTH-1];
              state_q    <= StSend;
            end else if (last_q) begin
              bit_data_q  <= 1'b0;
              latch_cnt_q <= (rst_cnt_in == '0) ? RST_CNT_WIDTH'(1) : rst_cnt_in;
              state_q     <= StLatch;
            end else begin
              pix_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end
          end
        end
        StLatch: begin
          if (latch_cnt_q == RST_CNT_WIDTH'(1)) begin
            frame_done_q <= 1'b1;
            pix_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end else begin
            latch_cnt_q <= latch_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_ready_out  = pix_ready_q;
  assign bit_rdy_out    = bit_rdy_q;
  assign bit_data_out   = bit_data_q;
  assign busy_out       = busy_q;
  assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_ws281x_bit_serializer.sv
// Directed bench for ws281x_bit_serializer: a small downstream responder answers each strobe
// with bit_done_in after a fixed delay while per-scenario tasks check the results.
module tb_ws281x_bit_serializer;

  logic        clk_in;
  logic        rst_n_in;
  logic        pix_valid_in;
  logic [23:0] pix_data_in;
  logic        pix_last_in;
  logic        pix_ready_out;
  logic        bit_rdy_out;
  logic        bit_data_out;
  logic        bit_done_in;
  logic [15:0] rst_cnt_in;
  logic        busy_out;
  logic        frame_done_out;

  ws281x_bit_serializer #(
    .PIX_WIDTH    (24),
    .RST_CNT_WIDTH(16)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .pix_valid_in  (pix_valid_in),
    .pix_data_in   (pix_data_in),
    .pix_last_in   (pix_last_in),
    .pix_ready_out (pix_ready_out),
    .bit_rdy_out   (bit_rdy_out),
    .bit_data_out  (bit_data_out),
    .bit_done_in   (bit_done_in),
    .rst_cnt_in    (rst_cnt_in),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks;
  int failures;

  logic [23:0] px_data[4];
  logic        px_last[4];
  int          px_n;
  bit          mutate;
  bit          stray;

  int          strobes;
  int          latch_cycles;
  int          latch_nz;
  int          frame_dones;
  int          fd_strobes;
  int          dbl;
  logic [63:0] bits_got;

  // Feeds px_* words and answers every strobe with bit_done_in 'delay' cycles later.
  // Stops on frame_done_out, after 'stop_at' strobes (if non-zero), or after max_cycles.
  task automatic run_frame(input int delay, input int max_cycles, input int stop_at);
    int idx;
    bit pend;
    bit awaiting;
    bit prev_rdy;
    int cnt;
    idx = 0; pend = 0; awaiting = 0; prev_rdy = 0; cnt = 0;
    strobes = 0; latch_cycles = 0; latch_nz = 0; frame_dones = 0;
    fd_strobes = 0; dbl = 0; bits_got = '0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk_in);
      if (frame_done_out) begin
        frame_dones++;
        fd_strobes = strobes;
        break;
      end
      if (bit_rdy_out) begin
        if (prev_rdy) dbl++;
        bits_got = {bits_got[62:0], bit_data_out};
        strobes++;
        awaiting = 1;
        cnt = delay;
      end else if (busy_out && !awaiting) begin
        latch_cycles++;
        if (bit_data_out) latch_nz++;
      end
      prev_rdy = bit_rdy_out;
      if (stop_at != 0 && strobes == stop_at) break;
      bit_done_in = 1'b0;
      if (stray && bit_rdy_out) bit_done_in = 1'b1;
      if (stray && busy_out && !bit_rdy_out && !awaiting && latch_cycles[0]) bit_done_in = 1'b1;
      if (awaiting) begin
        if (cnt == 0) begin
          bit_done_in = 1'b1;
          awaiting = 0;
        end else begin
          cnt--;
        end
      end
      if (pend) begin
        idx++;
        pend = 0;
      end
      if (idx < px_n) begin
        pix_valid_in = 1'b1;
        if (pix_ready_out) begin
          pix_data_in = px_data[idx];
          pix_last_in = px_last[idx];
          pend = 1;
        end else if (mutate) begin
          pix_data_in = ~px_data[idx];
          pix_last_in = ~px_last[idx];
        end else begin
          pix_data_in = px_data[idx];
          pix_last_in = px_last[idx];
        end
      end else begin
        pix_valid_in = 1'b0;
      end
    end
    bit_done_in  = 1'b0;
    pix_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    pix_valid_in = 1'b0; pix_data_in = '0; pix_last_in = 1'b0;
    bit_done_in = 1'b0; rst_cnt_in = 16'd10;
    mutate = 0; stray = 0; px_n = 0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (pix_ready_out !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", pix_ready_out);
    end
    checks++;
    if (bit_rdy_out !== 1'b0) begin
      failures++; $display("FAIL reset_bit_rdy got=%b exp=0", bit_rdy_out);
    end
    checks++;
    if (bit_data_out !== 1'b0) begin
      failures++; $display("FAIL reset_bit_data got=%b exp=0", bit_data_out);
    end
    checks++;
    if (busy_out !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy_out);
    end
    checks++;
    if (frame_done_out !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_out);
    end
    rst_n_in = 1'b1;
    #1;
    checks++;
    if (pix_ready_out !== 1'b0) begin
      failures++; $display("FAIL release_ready_early got=%b exp=0", pix_ready_out);
    end
    @(negedge clk_in);
    checks++;
    if (pix_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL release_ready got ready=%b busy=%b exp ready=1 busy=0", pix_ready_out, busy_out);
    end
  endtask

  task automatic test_idle_stray_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      bit_done_in = i[0];
      if (i > 0) begin
        checks++;
        if (bit_rdy_out !== 1'b0 || busy_out !== 1'b0 || pix_ready_out !== 1'b1) begin
          failures++;
          $display("FAIL idle_stray cyc=%0d got rdy=%b busy=%b ready=%b exp 0 0 1",
                   i, bit_rdy_out, busy_out, pix_ready_out);
        end
      end
    end
    bit_done_in = 1'b0;
  endtask

  task automatic test_single_pixel();
    px_data[0] = 24'hA50FF0; px_last[0] = 1'b1; px_n = 1;
    rst_cnt_in = 16'd10;
    run_frame(3, 2000, 0);
    checks++;
    if (strobes != 24 || bits_got[23:0] !== 24'hA50FF0) begin
      failures++;
      $display("FAIL single_bits got n=%0d bits=%h exp n=24 bits=a50ff0", strobes, bits_got[23:0]);
    end
    checks++;
    if (dbl != 0) begin
      failures++; $display("FAIL single_strobe_width got back_to_back=%0d exp=0", dbl);
    end
    checks++;
    if (latch_cycles != 10 || latch_nz != 0) begin
      failures++;
      $display("FAIL single_latch got cycles=%0d high=%0d exp cycles=10 high=0",
               latch_cycles, latch_nz);
    end
    checks++;
    if (frame_dones != 1 || fd_strobes != 24) begin
      failures++;
      $display("FAIL single_frame_done got=%0d after=%0d exp=1 after=24", frame_dones, fd_strobes);
    end
    @(negedge clk_in);
    checks++;
    if (frame_done_out !== 1'b0 || pix_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL single_after got fd=%b ready=%b busy=%b exp 0 1 0",
               frame_done_out, pix_ready_out, busy_out);
    end
  endtask

  task automatic test_back_to_back();
    px_data[0] = 24'hFFFFFF; px_last[0] = 1'b0;
    px_data[1] = 24'h000001; px_last[1] = 1'b1;
    px_n = 2;
    rst_cnt_in = 16'd4;
    run_frame(2, 3000, 0);
    checks++;
    if (strobes != 48 || bits_got[47:0] !== 48'hFFFFFF_000001) begin
      failures++;
      $display("FAIL b2b_bits got n=%0d bits=%h exp n=48 bits=ffffff000001", strobes, bits_got[47:0]);
    end
    checks++;
    if (latch_cycles != 4) begin
      failures++; $display("FAIL b2b_latch got=%0d exp=4", latch_cycles);
    end
    checks++;
    if (frame_dones != 1 || fd_strobes != 48) begin
      failures++;
      $display("FAIL b2b_frame_done got=%0d after=%0d exp=1 after=48", frame_dones, fd_strobes);
    end
    checks++;
    if (dbl != 0) begin
      failures++; $display("FAIL b2b_strobe_width got back_to_back=%0d exp=0", dbl);
    end
  endtask

  task automatic test_stray_done();
    px_data[0] = 24'h5A3C81; px_last[0] = 1'b1; px_n = 1;
    rst_cnt_in = 16'd7;
    stray = 1;
    run_frame(2, 2000, 0);
    stray = 0;
    checks++;
    if (strobes != 24 || bits_got[23:0] !== 24'h5A3C81) begin
      failures++;
      $display("FAIL stray_bits got n=%0d bits=%h exp n=24 bits=5a3c81", strobes, bits_got[23:0]);
    end
    checks++;
    if (latch_cycles != 7 || frame_dones != 1) begin
      failures++;
      $display("FAIL stray_latch got cycles=%0d fd=%0d exp cycles=7 fd=1", latch_cycles, frame_dones);
    end
  endtask

  task automatic test_zero_latch();
    px_data[0] = 24'h000080; px_last[0] = 1'b1; px_n = 1;
    rst_cnt_in = 16'd0;
    run_frame(1, 2000, 0);
    checks++;
    if (latch_cycles != 1 || latch_nz != 0) begin
      failures++;
      $display("FAIL zero_latch got cycles=%0d high=%0d exp cycles=1 high=0", latch_cycles, latch_nz);
    end
    checks++;
    if (frame_dones != 1 || bits_got[23:0] !== 24'h000080) begin
      failures++;
      $display("FAIL zero_frame got fd=%0d bits=%h exp fd=1 bits=000080", frame_dones, bits_got[23:0]);
    end
    @(negedge clk_in);
    checks++;
    if (frame_done_out !== 1'b0) begin
      failures++; $display("FAIL zero_fd_once got=%b exp=0", frame_done_out);
    end
  endtask

  task automatic test_reset_mid_pixel();
    bit saw_fd;
    px_data[0] = 24'hF0F0F0; px_last[0] = 1'b1; px_n = 1;
    rst_cnt_in = 16'd5;
    run_frame(2, 500, 5);
    checks++;
    if (strobes != 5 || bits_got[4:0] !== 5'b11110) begin
      failures++; $display("FAIL abort_prefix got n=%0d bits=%b exp n=5 bits=11110", strobes, bits_got[4:0]);
    end
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({pix_ready_out, bit_rdy_out, bit_data_out, busy_out, frame_done_out} !== 5'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%b exp=00000",
               {pix_ready_out, bit_rdy_out, bit_data_out, busy_out, frame_done_out});
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    saw_fd = 0;
    @(negedge clk_in);
    if (frame_done_out) saw_fd = 1;
    checks++;
    if (pix_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready got ready=%b busy=%b exp 1 0", pix_ready_out, busy_out);
    end
    px_data[0] = 24'h800001; px_last[0] = 1'b1;
    rst_cnt_in = 16'd3;
    run_frame(1, 2000, 0);
    checks++;
    if (saw_fd || strobes != 24 || bits_got[23:0] !== 24'h800001) begin
      failures++;
      $display("FAIL abort_restart got fd_early=%b n=%0d bits=%h exp 0 24 800001",
               saw_fd, strobes, bits_got[23:0]);
    end
    checks++;
    if (frame_dones != 1 || latch_cycles != 3) begin
      failures++;
      $display("FAIL abort_frame got fd=%0d latch=%0d exp fd=1 latch=3", frame_dones, latch_cycles);
    end
  endtask

  task automatic test_accept_sampling();
    px_data[0] = 24'h3C0001; px_last[0] = 1'b0;
    px_data[1] = 24'hC3A5E7; px_last[1] = 1'b1;
    px_n = 2;
    rst_cnt_in = 16'd2;
    mutate = 1;
    run_frame(2, 3000, 0);
    mutate = 0;
    checks++;
    if (strobes != 48 || bits_got[47:0] !== 48'h3C0001_C3A5E7) begin
      failures++;
      $display("FAIL sample_bits got n=%0d bits=%h exp n=48 bits=3c0001c3a5e7", strobes, bits_got[47:0]);
    end
    checks++;
    if (frame_dones != 1 || latch_cycles != 2) begin
      failures++;
      $display("FAIL sample_frame got fd=%0d latch=%0d exp fd=1 latch=2", frame_dones, latch_cycles);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle_stray_done();
    test_single_pixel();
    test_back_to_back();
    test_stray_done();
    test_zero_latch();
    test_reset_mid_pixel();
    test_accept_sampling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
